// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data-memory request/grant/response
// handshake, stalls the pipeline while an access is in flight, aligns store
// data and strobes, extracts/extends load data and registers MEM/WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  exmem_datatype_i,
  input  logic [31:0] exmem_aluout_i,
  input  logic [31:0] exmem_dm_data_i,
  input  logic [31:0] exmem_pc2reg_i,
  input  logic [4:0]  exmem_rd_addr_i,
  input  logic        exmem_reg_wr_i,
  input  logic        exmem_rd_src_i,
  input  logic        exmem_dm2reg_i,
  input  logic        exmem_dm_rd_i,
  input  logic        exmem_dm_wr_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_stall_o,
  output logic        mem_misalign_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_wstrb_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] wb_rd_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_wr_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic        mem_op;
  logic        is_byte, is_half, is_word;
  logic        addr_misaligned;
  logic        misaligned;
  logic        done;
  logic [1:0]  offset;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;
  logic [31:0] alu_or_link;
  logic [31:0] result;
  logic [31:0] wb_rd_data_q;
  logic [4:0]  wb_rd_addr_q;
  logic        wb_reg_wr_q;

  assign offset  = exmem_aluout_i[1:0];
  assign mem_op  = exmem_dm_rd_i | exmem_dm_wr_i;
  assign is_byte = (exmem_datatype_i[1:0] == 2'b00);
  assign is_half = (exmem_datatype_i[1:0] == 2'b01);
  assign is_word = ~is_byte & ~is_half;

  assign addr_misaligned = (is_half & offset[0]) | (is_word & (offset != 2'b00));
  // Misalignment is only judged on entry; later states only see aligned ops.
  assign misaligned      = mem_op & addr_misaligned & (state_q == StIdle);

  assign done = ~mem_op | misaligned
              | ((state_q == StReq) & dm_gnt_i & exmem_dm_wr_i)
              | ((state_q == StWait) & dm_rvalid_i);

  assign mem_stall_o    = ~done;
  assign mem_misalign_o = misaligned;

  // Bus outputs derive from the held EX/MEM register, so they stay stable until gnt.
  assign dm_req_o  = (state_q == StReq);
  assign dm_we_o   = exmem_dm_wr_i;
  assign dm_addr_o = {exmem_aluout_i[31:2], 2'b00};

  // Store lane replication and byte strobes.
  always_comb begin
    dm_wdata_o = exmem_dm_data_i;
    dm_wstrb_o = 4'b1111;
    if (is_byte) begin
      dm_wdata_o = {4{exmem_dm_data_i[7:0]}};
      dm_wstrb_o = 4'b0001 << offset;
    end else if (is_half) begin
      dm_wdata_o = {2{exmem_dm_data_i[15:0]}};
      dm_wstrb_o = 4'b0011 << offset;
    end
  end

  // Load extraction: shift selected lane down, then sign- or zero-extend.
  assign rdata_shifted = dm_rdata_i >> {offset, 3'b000};
  always_comb begin
    load_data = dm_rdata_i;
    if (is_byte) begin
      load_data = {{24{~exmem_datatype_i[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
    end else if (is_half) begin
      load_data = {{16{~exmem_datatype_i[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
    end
  end

  assign alu_or_link   = exmem_rd_src_i ? exmem_pc2reg_i : exmem_aluout_i;
  assign mem_rd_data_o = alu_or_link;
  assign result        = exmem_dm2reg_i ? load_data : alu_or_link;

  // Access FSM; any completed (or vanished) op returns to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (mem_op && !addr_misaligned) state_q <= StReq;
        StReq: begin
          if (!mem_op) begin
            state_q <= StIdle;
          end else if (dm_gnt_i) begin
            state_q <= exmem_dm_wr_i ? StIdle : StWait;
          end
        end
        StWait: if (!mem_op || dm_rvalid_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // MEM/WB register: capture on completion, bubble while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_rd_data_q <= 32'h0;
      wb_rd_addr_q <= 5'h0;
      wb_reg_wr_q  <= 1'b0;
    end else if (done) begin
      wb_rd_data_q <= result;
      wb_rd_addr_q <= exmem_rd_addr_i;
      wb_reg_wr_q  <= exmem_reg_wr_i & ~(misaligned & exmem_dm_rd_i);
    end else begin
      wb_reg_wr_q  <= 1'b0;
    end
  end

  assign wb_rd_data_o = wb_rd_data_q;
  assign wb_rd_addr_o = wb_rd_addr_q;
  assign wb_reg_wr_o  = wb_reg_wr_q;

endmodule
